sprite_draw_queue: RTL

- Upstream neighbour of the sprite driver.
- Assembles 6-byte sprite draw commands arriving byte-serially from the host command interface.
- Buffers assembled commands in a FIFO and presents the head entry as show-ahead fields (id, x, y, scale) with empty/dequeue handshake to the sprite driver.
- The queue is flushed whenever the framebuffer is being reset, so each frame starts with an empty draw list.

---
 rtl/sprite_pkg.sv | 14 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/sprite_draw_queue.sv | 69 ++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite command type, framing length and assembler state.
package sprite_pkg;
    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } sprite_cmd_t;
    localparam int SPRITE_CMD_BYTES = 6;
    typedef enum logic [2:0] {S_ID, S_XH, S_XL, S_YH, S_YL, S_SC} asm_state_t;
    function automatic asm_state_t next_state(asm_state_t s);
        return s == S_SC ? S_ID : asm_state_t'(s + 3'd1);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with registered head and occupancy count.
module sync_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             fb_resetting,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     head_q, head_d;
    logic             do_push, do_pop;
    assign empty   = cnt_q == '0;
    assign full    = cnt_q == CNT_W'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = head_q;
    assign count   = cnt_q;
    // Head is loaded from the post-edge view of the array so a new entry shows one cycle after its write.
    always_comb begin
        wr_d   = wr_q + AW'(do_push);
        rd_d   = rd_q + AW'(do_pop);
        cnt_d  = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        head_d = (do_push && wr_q == rd_d) ? wdata : (cnt_d == '0 ? head_q : mem[rd_d]);
    end
    always_ff @(posedge clock)
        if (do_push) mem[wr_q] <= wdata;
    always_ff @(posedge clock or posedge fb_resetting)
        if (fb_resetting) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
endmodule

// File: rtl/sprite_draw_queue.sv
// sprite_draw_queue: assembles byte-serial sprite commands and queues them for the sprite driver.
module sprite_draw_queue
    import sprite_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             fb_resetting,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_byte,
    output logic             cmd_ready,
    input  logic             cmd_sync,
    input  logic             sprite_queue_dequeue,
    output logic             sprite_queue_is_empty,
    output logic [7:0]       sprite_queue_sprite_id,
    output logic [15:0]      sprite_queue_sprite_x,
    output logic [15:0]      sprite_queue_sprite_y,
    output logic [7:0]       sprite_queue_sprite_scale,
    output logic [CNT_W-1:0] queue_count,
    output logic             overflow,
    output logic             underflow
);
    asm_state_t  state_q, state_d;
    logic [39:0] part_q, part_d;
    logic        overflow_q, overflow_d, underflow_q, underflow_d;
    logic        full, accept, push;
    sprite_cmd_t wdata, head;
    assign cmd_ready = !(state_q == S_SC && full);
    assign accept    = cmd_valid && cmd_ready && !cmd_sync;
    assign push      = accept && state_q == S_SC;
    assign wdata     = sprite_cmd_t'({part_q, cmd_byte});
    // The first five bytes shift in as {id, x, y}; the scale byte goes straight to the FIFO.
    always_comb begin
        part_d      = (accept && state_q != S_SC) ? {part_q[31:0], cmd_byte} : part_q;
        state_d     = cmd_sync ? S_ID : (accept ? next_state(state_q) : state_q);
        overflow_d  = overflow_q || (cmd_sync && state_q != S_ID) || (cmd_valid && !cmd_ready);
        underflow_d = underflow_q || (sprite_queue_dequeue && sprite_queue_is_empty);
    end
    always_ff @(posedge clock or posedge fb_resetting)
        if (fb_resetting) begin
            state_q     <= S_ID;
            part_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            part_q      <= part_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    sync_fifo #(.W($bits(sprite_cmd_t)), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clock       (clock),
        .fb_resetting(fb_resetting),
        .push        (push),
        .wdata       (wdata),
        .pop         (sprite_queue_dequeue),
        .head        (head),
        .empty       (sprite_queue_is_empty),
        .full        (full),
        .count       (queue_count)
    );
    assign sprite_queue_sprite_id    = head.id;
    assign sprite_queue_sprite_x     = head.x;
    assign sprite_queue_sprite_y     = head.y;
    assign sprite_queue_sprite_scale = head.scale;
    assign overflow                  = overflow_q;
    assign underflow                 = underflow_q;
endmodule
